// File: rtl/pattern_scan_arbiter.sv
// Round-robin front end for one shared serial 4-bit pattern detector.
// Latency: a word accepted in cycle T shifts on T+1..T+WORD_W, and its result pulses at T+WORD_W+1.
// Backpressure: req*_ready is high only in IDLE, only for the granted requester, and only while it is valid.
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   cfg_we, cfg_pat       - pattern write; honoured only in IDLE
//   reqN_valid/data/ready - word request handshake, one per requester
//   ser_valid, ser_bit    - bit shifted into the detection window this cycle
//   busy                  - high while a word is being scanned or reported
//   res_valid/src/count   - one-cycle result pulse; src/count hold until the next result
module pattern_scan_arbiter #(
    parameter int WORD_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pat,
    input  logic              req0_valid,
    input  logic [WORD_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [WORD_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              ser_valid,
    output logic              ser_bit,
    output logic              busy,
    output logic              res_valid,
    output logic              res_src,
    output logic [CNT_W-1:0]  res_count
);

    localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [PAT_W-1:0] PAT_RST  = PAT_W'(4'b1101);
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WORD_W - 1);
    // A window is only meaningful once it holds PAT_W bits of the current word.
    localparam logic [BC_W-1:0]  FULL_WIN = BC_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [PAT_W-1:0]   pattern;
    logic               rr_ptr;
    logic [WORD_W-1:0]  shreg;
    logic [PAT_W-1:0]   window;
    logic [BC_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]   match_cnt;
    logic               cur_src;

    logic               grant0;
    logic               grant1;
    logic               handshake;
    logic               hs_src;
    logic               msb;
    logic [PAT_W-1:0]   win_nxt;
    logic               hit;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               last_bit;

    // Arbitration: a lone requester always wins; on contention rr_ptr picks.
    assign grant0 = req0_valid & (~req1_valid | ~rr_ptr);
    assign grant1 = req1_valid & (~req0_valid |  rr_ptr);

    // Ready is gated with reset so nothing is advertised while the block is held in reset.
    assign req0_ready = (state == IDLE) & ~reset & grant0;
    assign req1_ready = (state == IDLE) & ~reset & grant1;
    assign handshake  = req0_ready | req1_ready;
    assign hs_src     = req1_ready;

    // Serial datapath: MSB of the word enters bit 0 of the window.
    assign msb      = shreg[WORD_W-1];
    assign win_nxt  = {window[PAT_W-2:0], msb};
    assign hit      = (win_nxt == pattern) && (bit_cnt >= FULL_WIN);
    assign cnt_nxt  = match_cnt + CNT_W'(hit);
    assign last_bit = (bit_cnt == LAST_BIT);

    assign ser_valid = (state == SHIFT);
    assign ser_bit   = (state == SHIFT) & msb;
    assign busy      = (state != IDLE);
    assign res_valid = (state == REPORT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (handshake) state_nxt = SHIFT;
            SHIFT:   if (last_bit)  state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pattern   <= PAT_RST;
            rr_ptr    <= 1'b0;
            shreg     <= '0;
            window    <= '0;
            bit_cnt   <= '0;
            match_cnt <= '0;
            cur_src   <= 1'b0;
            res_src   <= 1'b0;
            res_count <= '0;
        end else begin
            state <= state_nxt;

            if (state == IDLE) begin
                // A write coinciding with a handshake is seen by that word,
                // because scanning only starts on the following cycle.
                if (cfg_we) begin
                    pattern <= cfg_pat;
                end
                if (handshake) begin
                    shreg     <= hs_src ? req1_data : req0_data;
                    cur_src   <= hs_src;
                    window    <= '0;
                    bit_cnt   <= '0;
                    match_cnt <= '0;
                    rr_ptr    <= ~hs_src;
                end
            end

            if (state == SHIFT) begin
                shreg     <= {shreg[WORD_W-2:0], 1'b0};
                window    <= win_nxt;
                bit_cnt   <= bit_cnt + BC_W'(1);
                match_cnt <= cnt_nxt;
                // Result registers are loaded with the final count (including
                // a match on the last bit) so they are valid throughout REPORT.
                if (last_bit) begin
                    res_src   <= cur_src;
                    res_count <= cnt_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Self-checking bench for pattern_scan_arbiter.
// Latency: n/a (drives handshakes and scoreboards results against queued expectations).
// Backpressure: requesters hold valid/data until ready, as a compliant producer would.
module tb_pattern_scan_arbiter;

    logic       clk;
    logic       reset;
    logic       cfg_we;
    logic [3:0] cfg_pat;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       ser_valid;
    logic       ser_bit;
    logic       busy;
    logic       res_valid;
    logic       res_src;
    logic [3:0] res_count;

    pattern_scan_arbiter #(.WORD_W(8), .PAT_W(4), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_pat    (cfg_pat),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .ser_valid  (ser_valid),
        .ser_bit    (ser_bit),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_src    (res_src),
        .res_count  (res_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cfg;
        logic [3:0] pat;
        logic       src;
        logic [7:0] data;
        logic [3:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic       src;
        logic [3:0] cnt;
    } exp_t;

    vec_t vecs [6];
    exp_t exp_q [$];
    int   hs_src_q [$];
    int   hs_cyc_q [$];
    logic ser_log [$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_hs  = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // One clock: sample the handshake just before the edge, then the
    // registered outputs on the falling edge.
    task automatic step();
        exp_t e;
        #1;
        if (req0_valid && req0_ready) begin
            hs_src_q.push_back(0);
            hs_cyc_q.push_back(cyc);
            last_hs = cyc;
        end
        if (req1_valid && req1_ready) begin
            hs_src_q.push_back(1);
            hs_cyc_q.push_back(cyc);
            last_hs = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (ser_valid) ser_log.push_back(ser_bit);
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_res actual=src%0d/count%0d required=no_result", res_src, res_count);
            end else begin
                e = exp_q.pop_front();
                check("res_src", int'(res_src), int'(e.src));
                check("res_count", int'(res_count), int'(e.cnt));
                check("res_latency", cyc - last_hs, 9);
            end
        end
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_src_q.size() < target && n < 40) begin
            step();
            n++;
        end
        if (hs_src_q.size() < target) fail_now("handshake_timeout");
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now("result_timeout");
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic send_word(input vec_t v);
        exp_t e;
        int   base;
        int   word;
        ser_log.delete();
        base  = hs_src_q.size();
        e.src = v.src;
        e.cnt = v.exp_cnt;
        exp_q.push_back(e);
        if (v.cfg) begin
            cfg_we  = 1'b1;
            cfg_pat = v.pat;
        end
        if (v.src) begin
            req1_valid = 1'b1;
            req1_data  = v.data;
        end else begin
            req0_valid = 1'b1;
            req0_data  = v.data;
        end
        wait_hs(base + 1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cfg_we     = 1'b0;
        if (hs_src_q.size() > base) check("grant_src", hs_src_q[base], int'(v.src));
        wait_drain();
        check("ser_bit_count", ser_log.size(), 8);
        if (ser_log.size() == 8) begin
            word = 0;
            for (int i = 0; i < 8; i++) word = (word << 1) | int'(ser_log[i]);
            check("ser_bits", word, int'(v.data));
        end
    endtask

    initial begin
        exp_t e;
        vec_t v;
        int   base;
        int   n;

        vecs[0] = '{cfg: 1'b0, pat: 4'b0000, src: 1'b0, data: 8'hDB, exp_cnt: 4'd2};
        vecs[1] = '{cfg: 1'b1, pat: 4'b1111, src: 1'b0, data: 8'hFF, exp_cnt: 4'd5};
        vecs[2] = '{cfg: 1'b1, pat: 4'b0000, src: 1'b0, data: 8'h0F, exp_cnt: 4'd1};
        vecs[3] = '{cfg: 1'b1, pat: 4'b1101, src: 1'b1, data: 8'hDB, exp_cnt: 4'd2};
        vecs[4] = '{cfg: 1'b1, pat: 4'b1011, src: 1'b1, data: 8'hB5, exp_cnt: 4'd1};
        vecs[5] = '{cfg: 1'b1, pat: 4'b0101, src: 1'b0, data: 8'h55, exp_cnt: 4'd3};

        reset      = 1'b1;
        cfg_we     = 1'b0;
        cfg_pat    = 4'b0000;
        req0_valid = 1'b1;
        req0_data  = 8'hA5;
        req1_valid = 1'b1;
        req1_data  = 8'h5A;

        // Reset defaults, with both requesters asserting valid.
        step();
        step();
        check("rst_ser_valid", int'(ser_valid), 0);
        check("rst_ser_bit",   int'(ser_bit),   0);
        check("rst_busy",      int'(busy),      0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_src",   int'(res_src),   0);
        check("rst_res_count", int'(res_count), 0);
        check("rst_req0_ready", int'(req0_ready), 0);
        check("rst_req1_ready", int'(req1_ready), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset      = 1'b0;
        step();

        // Table-driven words; the first relies on the reset pattern 1101.
        for (int i = 0; i < 6; i++) send_word(vecs[i]);

        // Round-robin with both requesters continuously valid.
        do_reset();
        base  = hs_src_q.size();
        e.src = 1'b0; e.cnt = 4'd2; exp_q.push_back(e);
        e.src = 1'b1; e.cnt = 4'd0; exp_q.push_back(e);
        e.src = 1'b0; e.cnt = 4'd2; exp_q.push_back(e);
        req0_valid = 1'b1;
        req0_data  = 8'hDB;
        req1_valid = 1'b1;
        req1_data  = 8'h00;
        wait_hs(base + 3);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_drain();
        if (hs_src_q.size() >= base + 3) begin
            check("rr_grant0", hs_src_q[base],     0);
            check("rr_grant1", hs_src_q[base + 1], 1);
            check("rr_grant2", hs_src_q[base + 2], 0);
            check("rr_gap01", hs_cyc_q[base + 1] - hs_cyc_q[base],     10);
            check("rr_gap12", hs_cyc_q[base + 2] - hs_cyc_q[base + 1], 10);
        end

        // Pattern write during SHIFT is ignored.
        base  = hs_src_q.size();
        e.src = 1'b0; e.cnt = 4'd2; exp_q.push_back(e);
        req0_valid = 1'b1;
        req0_data  = 8'hDB;
        wait_hs(base + 1);
        req0_valid = 1'b0;
        cfg_we     = 1'b1;
        cfg_pat    = 4'b0000;
        for (int i = 0; i < 4; i++) step();
        check("busy_in_shift", int'(busy), 1);
        cfg_we = 1'b0;
        wait_drain();
        // A subsequent idle write does apply.
        v = '{cfg: 1'b1, pat: 4'b0000, src: 1'b0, data: 8'h0F, exp_cnt: 4'd1};
        send_word(v);

        // Reset in the middle of a word aborts it.
        base  = hs_src_q.size();
        e.src = 1'b0; e.cnt = 4'd2; exp_q.push_back(e);
        req0_valid = 1'b1;
        req0_data  = 8'hDB;
        wait_hs(base + 1);
        req0_valid = 1'b0;
        n = 0;
        while (cyc < last_hs + 4 && n < 10) begin
            step();
            n++;
        end
        exp_q.delete();
        reset = 1'b1;
        step();
        check("abort_res_valid", int'(res_valid), 0);
        check("abort_busy",      int'(busy),      0);
        step();
        check("abort_ser_valid", int'(ser_valid), 0);
        check("abort_res_count", int'(res_count), 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        v = '{cfg: 1'b0, pat: 4'b0000, src: 1'b0, data: 8'hDB, exp_cnt: 4'd2};
        send_word(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
